// File: rtl/vga_ctrl_pkg.sv
// rtl/vga_ctrl_pkg.sv - shared types and indices for the ISP mode controller
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    LOCKOUT
  } cam_state_t;

  localparam int NUM_BTN = 4;

  localparam int BTN_CAM  = 0;
  localparam int BTN_NEXT = 1;
  localparam int BTN_PREV = 2;
  localparam int BTN_BYP  = 3;

  localparam int SW_CAM_BLOCK = 8;
  localparam int SW_MANUAL    = 15;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchronizer, stability counter and rising-press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      press   <= level & ~level_q;
      // Any disagreement must persist for DEBOUNCE_CYC cycles before it is believed
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/isp_mode_ctrl.sv
// rtl/isp_mode_ctrl.sv - button/switch front end committing filter settings on frame boundaries
module isp_mode_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC    = 250000,
  parameter int CAM_LOCKOUT_CYC = 25000000,
  parameter int MODE_W          = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        btn,
  input  logic [15:0]       sw,
  input  logic              v_sync,
  output logic [MODE_W-1:0] filter_sel,
  output logic              filter_bypass,
  output logic              cam_start,
  output logic              cam_busy,
  output logic              frame_commit
);

  localparam int LW = (CAM_LOCKOUT_CYC > 1) ? $clog2(CAM_LOCKOUT_CYC) : 1;
  localparam logic [LW-1:0] LOCK_MAX = LW'(CAM_LOCKOUT_CYC - 1);

  logic [NUM_BTN-1:0] press;
  logic [15:0]        sw_s1;
  logic [15:0]        sw_s2;
  logic               vs_s1;
  logic               vs_s2;
  logic               vs_d;
  logic               vs_fall;
  logic [MODE_W-1:0]  pending_sel;
  logic               pending_bypass;
  cam_state_t         state;
  cam_state_t         state_next;
  logic [LW-1:0]      lock_cnt;
  logic [LW-1:0]      lock_cnt_next;
  logic               unused_sw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn[i]),
      .press(press[i])
    );
  end

  assign vs_fall   = vs_d & ~vs_s2;
  assign unused_sw = ^{sw_s2[14:SW_CAM_BLOCK+1], sw_s2[SW_CAM_BLOCK-1:MODE_W]};

  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1          <= '0;
      sw_s2          <= '0;
      vs_s1          <= 1'b0;
      vs_s2          <= 1'b0;
      vs_d           <= 1'b0;
      pending_sel    <= '0;
      pending_bypass <= 1'b0;
      filter_sel     <= '0;
      filter_bypass  <= 1'b0;
      frame_commit   <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      vs_s1 <= v_sync;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;

      if (sw_s2[SW_MANUAL]) begin
        pending_sel <= sw_s2[MODE_W-1:0];
      end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
        pending_sel <= pending_sel + 1'b1;
      end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
        pending_sel <= pending_sel - 1'b1;
      end

      if (press[BTN_BYP]) begin
        pending_bypass <= ~pending_bypass;
      end

      // Commit uses the pre-update pending values; same-cycle presses wait a frame
      frame_commit <= vs_fall;
      if (vs_fall) begin
        filter_sel    <= pending_sel;
        filter_bypass <= pending_bypass;
      end
    end
  end

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      IDLE: begin
        if (press[BTN_CAM] && !sw_s2[SW_CAM_BLOCK]) begin
          state_next = START;
        end
      end
      START: begin
        state_next    = LOCKOUT;
        lock_cnt_next = '0;
      end
      LOCKOUT: begin
        if (lock_cnt == LOCK_MAX) begin
          state_next = IDLE;
        end else begin
          lock_cnt_next = lock_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lock_cnt  <= '0;
      cam_start <= 1'b0;
      cam_busy  <= 1'b0;
    end else begin
      state     <= state_next;
      lock_cnt  <= lock_cnt_next;
      cam_start <= (state_next == START);
      cam_busy  <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_isp_mode_ctrl.sv
// tb/tb_isp_mode_ctrl.sv - randomized scoreboard bench for isp_mode_ctrl
module tb_isp_mode_ctrl;

  localparam int DEB    = 4;
  localparam int LOCK   = 20;
  localparam int MODE_W = 2;
  localparam int NMODE  = 1 << MODE_W;

  logic              clk;
  logic              reset;
  logic [3:0]        btn;
  logic [15:0]       sw;
  logic              v_sync;
  logic [MODE_W-1:0] filter_sel;
  logic              filter_bypass;
  logic              cam_start;
  logic              cam_busy;
  logic              frame_commit;

  typedef struct packed {
    logic [MODE_W-1:0] sel;
    logic              byp;
  } commit_t;

  int      checks   = 0;
  int      failures = 0;
  commit_t commit_q[$];
  int      cam_q[$];
  int      m_sel    = 0;
  bit      m_byp    = 0;
  commit_t cur;
  int      busy_run = 0;

  isp_mode_ctrl #(
    .DEBOUNCE_CYC   (DEB),
    .CAM_LOCKOUT_CYC(LOCK),
    .MODE_W         (MODE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .sw           (sw),
    .v_sync       (v_sync),
    .filter_sel   (filter_sel),
    .filter_bypass(filter_bypass),
    .cam_start    (cam_start),
    .cam_busy     (cam_busy),
    .frame_commit (frame_commit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a commit or a camera start
  always @(negedge clk) begin
    if (reset) begin
      cur      = '0;
      busy_run = 0;
    end else begin
      if (frame_commit) begin
        check("commit_expected", 32'(commit_q.size() != 0), 32'd1);
        if (commit_q.size() != 0) cur = commit_q.pop_front();
      end
      check("filter_sel", 32'(filter_sel), 32'(cur.sel));
      check("filter_bypass", 32'(filter_bypass), 32'(cur.byp));
      if (cam_start) begin
        check("cam_start_expected", 32'(cam_q.size() != 0), 32'd1);
        if (cam_q.size() != 0) void'(cam_q.pop_front());
      end
      if (cam_busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("cam_busy_len", 32'(busy_run), 32'(LOCK + 1));
        busy_run = 0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [3:0] mask, input int hi, input int lo);
    btn = mask;
    step(hi);
    btn = 4'b0000;
    step(lo);
  endtask

  task automatic op_next();
    press(4'b0010, DEB + 6, DEB + 6);
    if (!sw[15]) m_sel = (m_sel + 1) % NMODE;
  endtask

  task automatic op_prev();
    press(4'b0100, DEB + 6, DEB + 6);
    if (!sw[15]) m_sel = (m_sel + NMODE - 1) % NMODE;
  endtask

  task automatic op_both();
    press(4'b0110, DEB + 6, DEB + 6);
  endtask

  task automatic op_byp();
    press(4'b1000, DEB + 6, DEB + 6);
    m_byp = !m_byp;
  endtask

  task automatic set_sw(input logic [15:0] val);
    sw = val;
    step(4);
    if (sw[15]) m_sel = int'(sw[MODE_W-1:0]);
  endtask

  task automatic frame();
    commit_t c;
    c.sel = MODE_W'(m_sel);
    c.byp = m_byp;
    commit_q.push_back(c);
    v_sync = 1'b0;
    step(4);
    v_sync = 1'b1;
    step(6);
    check("commit_seen", 32'(commit_q.size()), 32'd0);
  endtask

  task automatic cam(input bit blk);
    sw[8] = blk;
    step(3);
    if (!blk) cam_q.push_back(1);
    press(4'b0001, DEB + 6, DEB + 6);
    step(LOCK + 6);
    check("cam_start_seen", 32'(cam_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_filter_sel", 32'(filter_sel), 32'd0);
    check("rst_filter_bypass", 32'(filter_bypass), 32'd0);
    check("rst_cam_start", 32'(cam_start), 32'd0);
    check("rst_cam_busy", 32'(cam_busy), 32'd0);
    check("rst_frame_commit", 32'(frame_commit), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    btn    = 4'b0000;
    sw     = 16'h0000;
    v_sync = 1'b1;
    step(3);
    check_reset_outputs();
    reset = 1'b0;
    step(2);

    // Single next press, then a boundary
    op_next();
    frame();

    // Wrap forward through max, then back below zero
    op_next();
    op_next();
    op_next();
    frame();
    op_prev();
    frame();

    // Simultaneous next/prev, and a bouncy press
    op_both();
    frame();
    btn = 4'b0010;
    step(1);
    btn = 4'b0000;
    step(1);
    op_next();
    frame();

    // Camera: second press inside lockout is ignored, blocked press is dropped
    sw[8] = 1'b0;
    step(3);
    cam_q.push_back(1);
    press(4'b0001, 8, 8);
    press(4'b0001, 8, 8);
    step(LOCK + 6);
    check("cam_lockout_ignore", 32'(cam_q.size()), 32'd0);
    cam(1'b1);
    cam(1'b0);

    // Manual override wins over stepping; bypass toggle
    set_sw(16'h8002);
    op_next();
    op_next();
    frame();
    op_byp();
    frame();
    set_sw(16'h0000);

    // Reset in the middle of lockout with pending_sel=3
    set_sw(16'h8003);
    set_sw(16'h0000);
    cam_q.push_back(1);
    press(4'b0001, DEB + 6, 2);
    step(3);
    reset = 1'b1;
    commit_q.delete();
    cam_q.delete();
    m_sel = 0;
    m_byp = 0;
    step(1);
    check_reset_outputs();
    step(1);
    reset = 1'b0;
    cam(1'b0);
    frame();

    // Randomized mix of operations
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 6))
        0: op_next();
        1: op_prev();
        2: op_both();
        3: op_byp();
        4: frame();
        5: set_sw({$urandom_range(0, 1) == 0, 6'd0, sw[8], 6'd0, 2'($urandom_range(0, NMODE - 1))});
        default: cam(1'($urandom_range(0, 1)));
      endcase
    end
    frame();
    step(4);
    check("final_commit_q", 32'(commit_q.size()), 32'd0);
    check("final_cam_q", 32'(cam_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
